// File: rtl/and_gate_checker.sv
// and_gate_checker: response-side scoreboard for a 2-operand AND test interface.
// It accepts {a, b, c} vectors over a valid/ready handshake and checks each c
// against a & b. It counts vectors and mismatches and captures the first
// failing vector. It reports pass/fail once EXP_VECTORS vectors have been accepted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset; no run started, in_ready low
// RUN    | accepting vectors; in_ready and busy high
// DONE   | run complete; results held until start or reset
module and_gate_checker #(
  parameter int WIDTH       = 2,
  parameter int CNT_W       = 16,
  parameter int EXP_VECTORS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic [WIDTH-1:0] i_in_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_vec_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_fail_valid,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [WIDTH-1:0] o_fail_c,
  output logic [CNT_W-1:0] o_fail_index
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXP_VECTORS - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH-1:0] r_fail_c;
  logic [CNT_W-1:0] r_fail_index;

  logic             w_xfer;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;

  // Transfer qualification and the check itself. Both are only meaningful in RUN.
  assign w_xfer     = i_in_valid && r_in_ready;
  assign w_mismatch = (i_in_c != (i_in_a & i_in_b));
  assign w_err_next = (w_mismatch && (r_err_count != '1)) ? r_err_count + CNT_W'(1)
                                                          : r_err_count;

  // Sequencer: the state and every registered output are updated together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_vec_count  <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_c     <= '0;
      r_fail_index <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_RUN;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_c     <= '0;
            r_fail_index <= '0;
          end
        end
        S_RUN: begin
          // A start pulse here is deliberately ignored.
          if (w_xfer) begin
            r_vec_count <= r_vec_count + CNT_W'(1);
            r_err_count <= w_err_next;
            if (w_mismatch && !r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_a     <= i_in_a;
              r_fail_b     <= i_in_b;
              r_fail_c     <= i_in_c;
              r_fail_index <= r_vec_count;
            end
            if (r_vec_count == LAST_IDX) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= (r_err_count == '0) && !w_mismatch;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_vec_count  = r_vec_count;
  assign o_err_count  = r_err_count;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_a     = r_fail_a;
  assign o_fail_b     = r_fail_b;
  assign o_fail_c     = r_fail_c;
  assign o_fail_index = r_fail_index;

endmodule

// File: tb/tb_and_gate_checker.sv
// Directed bench for and_gate_checker. Expected values are hand-computed.
module tb_and_gate_checker;

  localparam int WIDTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic             busy, done, pass, fail_valid;
  logic [CNT_W-1:0] vec_count, err_count, fail_index;
  logic [WIDTH-1:0] fail_a, fail_b, fail_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  and_gate_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .EXP_VECTORS(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .i_in_c      (in_c),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_vec_count (vec_count),
    .o_err_count (err_count),
    .o_fail_valid(fail_valid),
    .o_fail_a    (fail_a),
    .o_fail_b    (fail_b),
    .o_fail_c    (fail_c),
    .o_fail_index(fail_index)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one vector and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    int n;
    n = 0;
    in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_accept_timeout", 32'(n < 20), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;

    // T1 reset
    step(); step();
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_pass", 32'(pass), 32'd0);
    chk("t1_vec_count", 32'(vec_count), 32'd0);
    chk("t1_err_count", 32'(err_count), 32'd0);
    chk("t1_fail_valid", 32'(fail_valid), 32'd0);
    chk("t1_fail_index", 32'(fail_index), 32'd0);
    chk("t1_fail_abc", 32'({fail_a, fail_b, fail_c}), 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b11; in_c = 2'b11;
    step(); step(); step();
    chk("t1_idle_vec_count", 32'(vec_count), 32'd0);
    chk("t1_idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // T2 clean run
    pulse_start();
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    send(2'b00, 2'b00, 2'b00);
    send(2'b00, 2'b01, 2'b00);
    send(2'b01, 2'b00, 2'b00);
    chk("t2_not_done_yet", 32'(done), 32'd0);
    send(2'b01, 2'b01, 2'b01);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_vec_count", 32'(vec_count), 32'd4);
    chk("t2_err_count", 32'(err_count), 32'd0);
    chk("t2_fail_valid", 32'(fail_valid), 32'd0);
    // DONE ignores in_valid
    in_valid = 1'b1; step(); step(); in_valid = 1'b0;
    chk("t2_done_hold_vec", 32'(vec_count), 32'd4);

    // T3 single fault on vector 2
    pulse_start();
    chk("t3_cleared_vec", 32'(vec_count), 32'd0);
    send(2'b00, 2'b00, 2'b00);
    send(2'b00, 2'b01, 2'b00);
    send(2'b01, 2'b00, 2'b01);
    send(2'b01, 2'b01, 2'b01);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_err_count", 32'(err_count), 32'd1);
    chk("t3_fail_valid", 32'(fail_valid), 32'd1);
    chk("t3_fail_a", 32'(fail_a), 32'd1);
    chk("t3_fail_b", 32'(fail_b), 32'd0);
    chk("t3_fail_c", 32'(fail_c), 32'd1);
    chk("t3_fail_index", 32'(fail_index), 32'd2);

    // T4 two faults (vectors 1 and 3) with a stalled source
    pulse_start();
    send(2'b11, 2'b10, 2'b10);
    step(); step(); step();
    send(2'b00, 2'b01, 2'b01);
    step(); step(); step();
    send(2'b10, 2'b11, 2'b10);
    step(); step(); step();
    chk("t4_vec3", 32'(vec_count), 32'd3);
    chk("t4_not_done", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    send(2'b01, 2'b01, 2'b00);
    chk("t4_vec4", 32'(vec_count), 32'd4);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_err_count", 32'(err_count), 32'd2);
    chk("t4_fail_index", 32'(fail_index), 32'd1);
    chk("t4_fail_abc", 32'({fail_a, fail_b, fail_c}), 32'({2'b00, 2'b01, 2'b01}));

    // T5 start ignored in RUN, then start+valid together in DONE
    pulse_start();
    send(2'b10, 2'b10, 2'b00);
    send(2'b11, 2'b11, 2'b11);
    pulse_start();
    chk("t5_run_vec", 32'(vec_count), 32'd2);
    chk("t5_run_busy", 32'(busy), 32'd1);
    chk("t5_run_fail_idx", 32'(fail_index), 32'd0);
    send(2'b11, 2'b01, 2'b01);
    send(2'b10, 2'b01, 2'b00);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err_count), 32'd1);
    chk("t5_vec", 32'(vec_count), 32'd4);
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b11; in_c = 2'b00;
    pulse_start();
    in_valid = 1'b0;
    chk("t5_restart_busy", 32'(busy), 32'd1);
    chk("t5_restart_done", 32'(done), 32'd0);
    chk("t5_restart_vec", 32'(vec_count), 32'd0);
    chk("t5_restart_err", 32'(err_count), 32'd0);
    chk("t5_restart_fail_valid", 32'(fail_valid), 32'd0);
    chk("t5_restart_fail_abc", 32'({fail_a, fail_b, fail_c, fail_index}), 32'd0);

    // T6 reset mid-run after 2 vectors, one failing
    send(2'b01, 2'b11, 2'b01);
    send(2'b11, 2'b11, 2'b01);
    chk("t6_pre_err", 32'(err_count), 32'd1);
    chk("t6_pre_fail_valid", 32'(fail_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err_count), 32'd0);
    chk("t6_vec", 32'(vec_count), 32'd0);
    chk("t6_fail_valid", 32'(fail_valid), 32'd0);
    chk("t6_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
